// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared UART state, parity types and frame constants. Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_t;

    localparam int UART_MIN_BITS = 5;

    // Code 3 is reserved and treated as no parity.
    function automatic uart_parity_t decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock show-ahead FIFO with occupancy count. Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo : FIFO-fed UART transmitter, 5..DATA_W bits, N/E/O, 1/2 stop. Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_RATE      = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int NCLKS_PER_BIT = CLK_RATE / BAUD_RATE,
    parameter int DATA_W        = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             i_tx_data,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    input  logic [3:0]                    i_cfg_nbits,
    input  logic [1:0]                    i_cfg_parity,
    input  logic                          i_cfg_stop2,
    output logic                          o_tx_data,
    output logic                          o_tx_busy,
    output logic                          o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    import uart_pkg::*;

    localparam int BW = $clog2(NCLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);
    localparam logic [BW-1:0] BAUD_LAST = BW'(NCLKS_PER_BIT - 1);
    localparam logic [3:0]    NBITS_MIN = 4'(UART_MIN_BITS);
    localparam logic [3:0]    NBITS_MAX = 4'(DATA_W);

    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              load;

    uart_tx_state_t    state, state_next;
    logic [BW-1:0]     baud_cnt, baud_next;
    logic [IW-1:0]     bit_idx, idx_next;
    logic [IW-1:0]     last_idx, last_idx_next;
    logic [DATA_W-1:0] shift, shift_next;
    uart_parity_t      par_mode, par_next;
    logic              stop2, stop2_next;
    logic              line, line_next;

    logic [3:0]        nbits_clamped;
    logic [IW-1:0]     cfg_last;
    logic [DATA_W-1:0] bit_mask;
    logic              par_bit;
    logic              baud_last;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_tx_valid),
        .wdata (i_tx_data),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_count)
    );

    always_comb begin
        if (i_cfg_nbits < NBITS_MIN)      nbits_clamped = NBITS_MIN;
        else if (i_cfg_nbits > NBITS_MAX) nbits_clamped = NBITS_MAX;
        else                              nbits_clamped = i_cfg_nbits;
    end

    assign cfg_last = IW'(nbits_clamped - 4'd1);

    // Parity covers only the bits actually sent in this frame.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bit_mask[i] = (i <= int'(last_idx));
        end
    end

    assign par_bit   = (^(shift & bit_mask)) ^ (par_mode == PAR_ODD);
    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_next    = state;
        baud_next     = baud_cnt;
        idx_next      = bit_idx;
        shift_next    = shift;
        last_idx_next = last_idx;
        par_next      = par_mode;
        stop2_next    = stop2;
        load          = 1'b0;
        line_next     = 1'b1;

        case (state)
            IDLE:   load = !fifo_empty;
            START:  if (baud_last) state_next = DATA;
            DATA: begin
                if (baud_last) begin
                    if (bit_idx == last_idx) begin
                        idx_next   = '0;
                        state_next = (par_mode == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: if (baud_last) state_next = STOP;
            STOP: begin
                // bit_idx doubles as the stop-bit counter here.
                if (baud_last) begin
                    if (stop2 && (bit_idx == '0)) idx_next   = IW'(1);
                    else                          state_next = DONE;
                end
            end
            DONE: begin
                if (fifo_empty) state_next = IDLE;
                else            load       = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (state inside {START, DATA, PARITY, STOP}) begin
            baud_next = baud_last ? '0 : baud_cnt + 1'b1;
        end else begin
            baud_next = '0;
        end

        if (load) begin
            state_next    = START;
            shift_next    = fifo_rdata;
            last_idx_next = cfg_last;
            par_next      = decode_parity(i_cfg_parity);
            stop2_next    = i_cfg_stop2;
            idx_next      = '0;
            baud_next     = '0;
        end

        // The line is registered, so it is driven from the upcoming state.
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[idx_next];
            PARITY:  line_next = par_bit;
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            last_idx <= '0;
            par_mode <= PAR_NONE;
            stop2    <= 1'b0;
            line     <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= idx_next;
            shift    <= shift_next;
            last_idx <= last_idx_next;
            par_mode <= par_next;
            stop2    <= stop2_next;
            line     <= line_next;
        end
    end

    assign o_tx_data  = line;
    assign o_tx_busy  = (state != IDLE);
    assign o_tx_done  = (state == DONE);
    assign o_tx_ready = ~fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo : directed and random frame checks against a waveform model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int LOG_N = 16384;

    typedef struct {
        logic [7:0] d;
        logic [3:0] nb;
        logic [1:0] par;
        logic       s2;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] cfg_nbits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       line_out;
    logic       busy;
    logic       done;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic line_log [LOG_N];
    logic done_log [LOG_N];
    logic busy_log [LOG_N];
    frame_t exp_q[$];

    uart_tx_fifo #(
        .CLK_RATE      (4),
        .BAUD_RATE     (1),
        .NCLKS_PER_BIT (4),
        .DATA_W        (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .i_cfg_nbits  (cfg_nbits),
        .i_cfg_parity (cfg_parity),
        .i_cfg_stop2  (cfg_stop2),
        .o_tx_data    (line_out),
        .o_tx_busy    (busy),
        .o_tx_done    (done),
        .o_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            line_log[cyc] <= line_out;
            done_log[cyc] <= done;
            busy_log[cyc] <= busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line waveform of one frame: one entry per clock, then the DONE clock.
    function automatic int build(input frame_t f, output logic [63:0] ln, output logic [63:0] dn);
        int n;
        int pos;
        bit p;
        bit bits[$];
        n = (f.nb < 5) ? 5 : ((f.nb > 8) ? 8 : int'(f.nb));
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(f.d[i]);
            p = p ^ f.d[i];
        end
        if (f.par == 2'd1) bits.push_back(p);
        if (f.par == 2'd2) bits.push_back(!p);
        bits.push_back(1'b1);
        if (f.s2) bits.push_back(1'b1);
        ln  = '0;
        dn  = '0;
        pos = 0;
        foreach (bits[b]) begin
            for (int k = 0; k < 4; k++) begin
                ln[pos] = bits[b];
                pos++;
            end
        end
        ln[pos] = 1'b1;
        dn[pos] = 1'b1;
        return pos + 1;
    endfunction

    function automatic int total_len();
        int t;
        logic [63:0] a;
        logic [63:0] b;
        t = 0;
        foreach (exp_q[k]) t += build(exp_q[k], a, b);
        return t;
    endfunction

    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic s2);
        cfg_nbits  = nb;
        cfg_parity = par;
        cfg_stop2  = s2;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par, input logic s2);
        frame_t f;
        f.d = d; f.nb = nb; f.par = par; f.s2 = s2;
        exp_q.push_back(f);
    endtask

    task automatic push(input logic [7:0] d, output int acc);
        int w;
        w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("push_ready", 64'(tx_ready), 64'd1);
        acc = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_frames(input int start, input string tag);
        int cur;
        int len;
        logic [63:0] eln;
        logic [63:0] edn;
        logic [63:0] oln;
        logic [63:0] odn;
        cur = start;
        check({tag, "_pre_idle"}, 64'(line_log[start-1]), 64'd1);
        foreach (exp_q[k]) begin
            len = build(exp_q[k], eln, edn);
            oln = '0;
            odn = '0;
            for (int i = 0; i < len; i++) begin
                oln[i] = line_log[cur+i];
                odn[i] = done_log[cur+i];
            end
            check($sformatf("%s_f%0d_line", tag, k), oln, eln);
            check($sformatf("%s_f%0d_done", tag, k), odn, edn);
            cur += len;
        end
        check({tag, "_post_line"}, 64'(line_log[cur]), 64'd1);
        check({tag, "_post_busy"}, 64'(busy_log[cur]), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int c;
        int c0;
        int s;
        int tot;
        logic all_high;
        logic any_busy;
        logic [7:0] rd;
        logic [3:0] rnb;
        logic [1:0] rpar;
        logic rs2;

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        set_cfg(4'd8, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_line",  64'(line_out),   64'd1);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_done",  64'(done),       64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ready", 64'(tx_ready),   64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0xA5 from idle
        set_cfg(4'd8, 2'd0, 1'b0);
        expect_frame(8'hA5, 4'd8, 2'd0, 1'b0);
        tot = total_len();
        push(8'hA5, c);
        s = c + 2;
        wait_until(s + tot + 3);
        check("t1_done_pop_plus_41", 64'(done_log[c+1+41]), 64'd1);
        check("t1_done_before", 64'(done_log[c+1+40]), 64'd0);
        check_frames(s, "t1");

        // 7E2 0x41
        set_cfg(4'd7, 2'd1, 1'b1);
        expect_frame(8'h41, 4'd7, 2'd1, 1'b1);
        tot = total_len();
        push(8'h41, c);
        s = c + 2;
        wait_until(s + tot + 3);
        check_frames(s, "t2");

        // 5O1 0x1F, then clamped widths
        set_cfg(4'd5, 2'd2, 1'b0);
        expect_frame(8'h1F, 4'd5, 2'd2, 1'b0);
        tot = total_len();
        push(8'h1F, c);
        s = c + 2;
        wait_until(s + tot + 3);
        check_frames(s, "t3a");

        set_cfg(4'd2, 2'd1, 1'b0);
        expect_frame(8'hE3, 4'd2, 2'd1, 1'b0);
        tot = total_len();
        push(8'hE3, c);
        s = c + 2;
        wait_until(s + tot + 3);
        check_frames(s, "t3b");

        set_cfg(4'd12, 2'd3, 1'b0);
        expect_frame(8'h96, 4'd12, 2'd3, 1'b0);
        tot = total_len();
        push(8'h96, c);
        s = c + 2;
        wait_until(s + tot + 3);
        check_frames(s, "t3c");

        // back-to-back, FIFO fills
        set_cfg(4'd8, 2'd0, 1'b0);
        for (int i = 1; i <= 5; i++) expect_frame(8'(i), 4'd8, 2'd0, 1'b0);
        tot = total_len();
        push(8'h01, c0);
        for (int i = 2; i <= 5; i++) push(8'(i), c);
        check("t4_count_full", 64'(fifo_count), 64'd4);
        check("t4_ready_low",  64'(tx_ready),   64'd0);
        check("t4_push_cycles", 64'(c - c0), 64'd4);
        s = c0 + 2;
        wait_until(s + tot + 3);
        check_frames(s, "t4");

        // config change mid-frame
        set_cfg(4'd8, 2'd0, 1'b0);
        expect_frame(8'h5A, 4'd8, 2'd0, 1'b0);
        expect_frame(8'h3D, 4'd8, 2'd1, 1'b0);
        tot = total_len();
        push(8'h5A, c0);
        push(8'h3D, c);
        s = c0 + 2;
        wait_until(s + 14);
        set_cfg(4'd8, 2'd1, 1'b0);
        wait_until(s + tot + 3);
        check_frames(s, "t5");

        // reset at data bit 3 with two words queued
        set_cfg(4'd8, 2'd0, 1'b0);
        push(8'h55, c0);
        push(8'h66, c);
        push(8'h77, c);
        s = c0 + 2;
        check("t6_queued", 64'(fifo_count), 64'd2);
        wait_until(s + 17);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6_line",  64'(line_out),   64'd1);
        check("t6_busy",  64'(busy),       64'd0);
        check("t6_count", 64'(fifo_count), 64'd0);
        check("t6_ready", 64'(tx_ready),   64'd1);
        check("t6_done",  64'(done),       64'd0);
        wait_until(s + 120);
        all_high = 1'b1;
        any_busy = 1'b0;
        for (int i = s + 18; i < s + 118; i++) begin
            all_high = all_high & line_log[i];
            any_busy = any_busy | busy_log[i];
        end
        check("t6_no_frames_line", 64'(all_high), 64'd1);
        check("t6_no_frames_busy", 64'(any_busy), 64'd0);

        // random formats and data
        for (int r = 0; r < 12; r++) begin
            rd   = 8'($urandom);
            rnb  = 4'($urandom_range(0, 15));
            rpar = 2'($urandom_range(0, 3));
            rs2  = 1'($urandom_range(0, 1));
            set_cfg(rnb, rpar, rs2);
            expect_frame(rd, rnb, rpar, rs2);
            tot = total_len();
            push(rd, c);
            s = c + 2;
            wait_until(s + tot + 3);
            check_frames(s, $sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
